// File: rtl/dwt_pkg.sv
// Shared types and constants for the horizontal DWT row-pass scheduler.
package dwt_pkg;
    localparam int DEFAULT_MAX_SIDE_SIZE = 512;
    localparam int DEFAULT_MAX_LEVELS    = 5;
    localparam int MIN_LEVEL_SIDE        = 4;

    typedef logic [$clog2(DEFAULT_MAX_SIDE_SIZE):0]  side_t;
    typedef logic [$clog2(DEFAULT_MAX_LEVELS+1)-1:0] level_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } sched_state_e;
endpackage

// File: rtl/dwt_horizontal_scheduler_if.sv
// Read-request stream to the row datapath plus the monitored DWT output handshake.
interface dwt_horizontal_scheduler_if #(
    parameter int MaximumSideSize = 512
);
    localparam int RowW = $clog2(MaximumSideSize);
    localparam int ColW = RowW - 1;

    logic            req_valid;
    logic            req_ready;
    logic [RowW-1:0] req_row;
    logic [ColW-1:0] req_col;
    logic            req_eol;
    logic            dout_valid;
    logic            dout_ready;
    logic            dout_eol;

    modport master (
        output req_valid, req_row, req_col, req_eol,
        input  req_ready, dout_valid, dout_ready, dout_eol
    );

    modport slave (
        input  req_valid, req_row, req_col, req_eol,
        output req_ready, dout_valid, dout_ready, dout_eol
    );
endinterface

// File: rtl/dwt_row_credit.sv
// Counts rows issued but not yet seen at the DWT output; gates the start of new rows.
module dwt_row_credit #(
    parameter int MaxRowsInFlight = 2
) (
    input  logic clk,
    input  logic srst,
    input  logic row_issued,
    input  logic row_completed,
    output logic credit_ok,
    output logic underflow,
    output logic row_retired
);
    localparam int CntW = $clog2(MaxRowsInFlight + 1);

    logic [CntW-1:0] in_flight_reg;
    logic [CntW-1:0] in_flight_next;

    // A completion with nothing outstanding is a protocol error and is not counted.
    assign underflow   = row_completed && (in_flight_reg == '0);
    assign row_retired = row_completed && !underflow;
    assign credit_ok   = in_flight_reg < CntW'(MaxRowsInFlight);

    always_comb begin
        in_flight_next = in_flight_reg;
        if (row_issued && !row_retired) begin
            in_flight_next = in_flight_reg + CntW'(1);
        end else if (!row_issued && row_retired) begin
            in_flight_next = in_flight_reg - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            in_flight_reg <= '0;
        end else begin
            in_flight_reg <= in_flight_next;
        end
    end
endmodule

// File: rtl/dwt_horizontal_scheduler.sv
// Sequences the horizontal 9/7 DWT row pass: per level, S_L rows of S_L/2 sample pairs,
// throttled by row credit and fully drained before the next (half-size) level starts.
module dwt_horizontal_scheduler
    import dwt_pkg::*;
#(
    parameter int MaximumSideSize = 512,
    parameter int MaxLevels       = 5,
    parameter int MaxRowsInFlight = 2
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 start_i,
    input  logic [$clog2(MaximumSideSize):0]     side_size_i,
    input  logic [$clog2(MaxLevels+1)-1:0]       levels_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic                                 cfg_err_o,
    output logic                                 proto_err_o,
    output logic [$clog2(MaxLevels+1)-1:0]       level_o,
    output logic [$clog2(MaximumSideSize):0]     dwt_side_size_o,
    dwt_horizontal_scheduler_if.master           bus
);
    localparam int SideW  = $clog2(MaximumSideSize) + 1;
    localparam int LevelW = $clog2(MaxLevels + 1);
    localparam int RowW   = SideW - 1;
    localparam int ColW   = SideW - 2;

    sched_state_e      state_reg, state_next;
    logic [LevelW-1:0] levels_reg;
    logic [LevelW-1:0] level_reg;
    logic [SideW-1:0]  lvl_side_reg;
    logic [RowW-1:0]   row_reg;
    logic [ColW-1:0]   col_reg;
    logic [SideW-1:0]  done_rows_reg;
    logic              cfg_err_reg;
    logic              proto_err_reg;

    logic [SideW-1:0]  side_minus1;
    logic [LevelW-1:0] levels_minus1;
    logic [SideW-1:0]  side_at_last;
    logic              cfg_valid;
    logic              start_ok;
    logic              start_rejected;
    logic              req_valid;
    logic              req_eol;
    logic              last_row;
    logic              accept;
    logic              eol_accept;
    logic              last_accept;
    logic              row_completed;
    logic              credit_ok;
    logic              underflow;
    logic              row_retired;
    logic              last_level;
    logic              level_done;
    logic              level_advance;

    // The deepest level must still be at least MIN_LEVEL_SIDE samples wide.
    assign side_minus1   = side_size_i - SideW'(1);
    assign levels_minus1 = levels_i - LevelW'(1);
    assign side_at_last  = side_size_i >> levels_minus1;
    assign cfg_valid     = ((side_size_i & side_minus1) == '0)
                        && (side_size_i >= SideW'(8))
                        && (levels_i != '0)
                        && (levels_i <= LevelW'(MaxLevels))
                        && (side_at_last >= SideW'(MIN_LEVEL_SIDE));

    assign start_ok       = (state_reg == IDLE) && start_i && cfg_valid;
    assign start_rejected = (state_reg == IDLE) && start_i && !cfg_valid;

    // Credit only gates the first pair of a row; a started row always runs to its end.
    assign req_valid   = (state_reg == ISSUE) && ((col_reg != '0) || credit_ok);
    assign req_eol     = (state_reg == ISSUE)
                      && ({2'b00, col_reg} == (lvl_side_reg >> 1) - SideW'(1));
    assign last_row    = ({1'b0, row_reg} == lvl_side_reg - SideW'(1));
    assign accept      = req_valid && bus.req_ready;
    assign eol_accept  = accept && req_eol;
    assign last_accept = eol_accept && last_row;

    assign row_completed = bus.dout_valid && bus.dout_ready && bus.dout_eol;
    assign last_level    = (level_reg == levels_reg - LevelW'(1));
    assign level_done    = (state_reg == DRAIN) && (done_rows_reg == lvl_side_reg);
    assign level_advance = level_done && !last_level;

    dwt_row_credit #(
        .MaxRowsInFlight (MaxRowsInFlight)
    ) u_row_credit (
        .clk           (clk_i),
        .srst          (rst_i),
        .row_issued    (eol_accept),
        .row_completed (row_completed),
        .credit_ok     (credit_ok),
        .underflow     (underflow),
        .row_retired   (row_retired)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_ok) state_next = ISSUE;
            ISSUE:   if (last_accept) state_next = DRAIN;
            DRAIN:   if (level_done) state_next = last_level ? DONE : ISSUE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            levels_reg    <= '0;
            level_reg     <= '0;
            lvl_side_reg  <= '0;
            row_reg       <= '0;
            col_reg       <= '0;
            done_rows_reg <= '0;
            cfg_err_reg   <= 1'b0;
            proto_err_reg <= 1'b0;
        end else begin
            cfg_err_reg   <= start_rejected;
            proto_err_reg <= proto_err_reg | underflow;

            if (start_ok) begin
                levels_reg   <= levels_i;
                level_reg    <= '0;
                lvl_side_reg <= side_size_i;
                row_reg      <= '0;
                col_reg      <= '0;
            end else if (accept) begin
                if (req_eol) begin
                    col_reg <= '0;
                    row_reg <= row_reg + RowW'(1);
                end else begin
                    col_reg <= col_reg + ColW'(1);
                end
            end else if (level_advance) begin
                level_reg    <= level_reg + LevelW'(1);
                lvl_side_reg <= lvl_side_reg >> 1;
                row_reg      <= '0;
                col_reg      <= '0;
            end

            if (start_ok || level_advance) begin
                done_rows_reg <= '0;
            end else if (row_retired) begin
                done_rows_reg <= done_rows_reg + SideW'(1);
            end
        end
    end

    assign busy_o          = (state_reg == ISSUE) || (state_reg == DRAIN);
    assign done_o          = (state_reg == DONE);
    assign cfg_err_o       = cfg_err_reg;
    assign proto_err_o     = proto_err_reg;
    assign level_o         = level_reg;
    assign dwt_side_size_o = lvl_side_reg;

    assign bus.req_valid = req_valid;
    assign bus.req_row   = row_reg;
    assign bus.req_col   = col_reg;
    assign bus.req_eol   = req_eol;
endmodule
